// File: rtl/one_bit_comparator.sv
// Single-bit equality/magnitude comparator with registered eq/neq/l/g flags.
// An optional input register stage adds one cycle of latency.
module one_bit_comparator #(
  parameter bit REG_INPUTS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic eq,
  output logic neq,
  output logic l,
  output logic g
);

  logic a_cmp;
  logic b_cmp;

  generate
    if (REG_INPUTS) begin : g_in_reg
      logic a_q, a_d;
      logic b_q, b_d;

      always_comb begin
        a_d = a;
        b_d = b;
      end

      // Input stage clears to operands (0,0) so it agrees with the output reset values.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= 1'b0;
          b_q <= 1'b0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_cmp = a_q;
      assign b_cmp = b_q;
    end else begin : g_in_direct
      assign a_cmp = a;
      assign b_cmp = b;
    end
  endgenerate

  logic eq_q, eq_d;
  logic neq_q, neq_d;
  logic l_q, l_d;
  logic g_q, g_d;

  always_comb begin
    eq_d  = ~(a_cmp ^ b_cmp);
    neq_d = ~(~(a_cmp & ~b_cmp) & ~(~a_cmp & b_cmp));
    l_d   = ~a_cmp & b_cmp;
    g_d   = a_cmp & ~b_cmp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q  <= 1'b1;
      neq_q <= 1'b0;
      l_q   <= 1'b0;
      g_q   <= 1'b0;
    end else begin
      eq_q  <= eq_d;
      neq_q <= neq_d;
      l_q   <= l_d;
      g_q   <= g_d;
    end
  end

  assign eq  = eq_q;
  assign neq = neq_q;
  assign l   = l_q;
  assign g   = g_q;

endmodule

// File: tb/tb_one_bit_comparator.sv
// Scoreboard bench for one_bit_comparator: drives both latency variants with
// the same operands and checks every output cycle against a behavioural model.
module tb_one_bit_comparator;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic eq0, neq0, l0, g0;
  logic eq1, neq1, l1, g1;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic sa, sb;
  bit   done;

  one_bit_comparator #(.REG_INPUTS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .eq(eq0), .neq(neq0), .l(l0), .g(g0)
  );

  one_bit_comparator #(.REG_INPUTS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .eq(eq1), .neq(neq1), .l(l1), .g(g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {eq,neq,l,g} from operand magnitudes.
  function automatic logic [3:0] ref_cmp(input int unsigned x, input int unsigned y);
    return {x == y, x != y, x < y, x > y};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and predict what each DUT shows after the next edge.
  task automatic step(input logic r, input logic va, input logic vb);
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    exp_q0.push_back(r ? ref_cmp(0, 0) : ref_cmp(int'(va), int'(vb)));
    exp_q1.push_back(r ? ref_cmp(0, 0) : ref_cmp(int'(sa), int'(sb)));
    sa = r ? 1'b0 : va;
    sb = r ? 1'b0 : vb;
  endtask

  // Monitor: one result per cycle, no handshake.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        check("dut0_out", {eq0, neq0, l0, g0}, e);
        check("dut0_inv", {3'b000, (eq0 === ~neq0) && (neq0 === (l0 | g0)) && ((l0 & g0) === 1'b0)}, 4'b0001);
      end
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        check("dut1_out", {eq1, neq1, l1, g1}, e);
        check("dut1_inv", {3'b000, (eq1 === ~neq1) && (neq1 === (l1 | g1)) && ((l1 & g1) === 1'b0)}, 4'b0001);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    sa  = 1'b0;
    sb  = 1'b0;
    done = 1'b0;

    // Reset held with inputs that would otherwise give g=1.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Exhaustive sweep on consecutive cycles.
    for (int i = 0; i < 4; i++) step(1'b0, i[1], i[0]);

    // Slow toggle: b every 10 cycles, a every 20 cycles.
    for (int c = 0; c < 40; c++) step(1'b0, ((c / 20) % 2) == 1, ((c / 10) % 2) == 1);

    // Latency step (0,0) -> (1,0).
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Mid-stream reset while (0,1) is applied.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Random operands with occasional resets.
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom));

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("drain", 4'(exp_q0.size() + exp_q1.size()), 4'd0);
    done = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
